axi_rd_responder: RTL
=====================

# axi_rd_responder

AXI4 read-channel responder backed by a word-addressed on-chip memory. It is the memory-side counterpart to the instruction-fetch read initiator: it accepts AR requests, waits a programmable access latency, then returns single or burst R beats. It is used as the simulation memory behind the fetch path, and as a standalone stimulus target in unit benches.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words in the backing store; must be a power of two.
- BASE_ADDR, 32'h80000000: byte address of word 0.
- LATENCY, 2: wait cycles between the AR handshake and the first R beat (0–15).
- ID_W, 4: width of the ARID and RID fields.
- INIT_FILE, "": hex image loaded with $readmemh at time 0 when the string is non-empty.

Ports:
- clock, input, 1: clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-high reset.
- arvalid, input, 1: read address valid.
- arready, output, 1: read address ready.
- araddr, input, 32: byte address.
- arid, input, ID_W: transaction ID.
- arlen, input, 8: number of beats minus 1.
- arsize, input, 3: beat size; only 3'b010 (4 bytes) is supported.
- arburst, input, 2: burst type; 00 FIXED, 01 INCR, 10 WRAP.
- rvalid, output, 1: read data valid.
- rready, input, 1: read data ready.
- rdata, output, 32: read data.
- rresp, output, 2: 00 OKAY, 10 SLVERR, 11 DECERR.
- rlast, output, 1: final beat of the burst.
- rid, output, ID_W: echoes the captured arid.

## Operation
- There are three states: IDLE, DELAY and BURST. Only one transaction is outstanding at a time.
- **IDLE:**
  - arready=1.
  - On arvalid&arready the block captures addr, id, len, burst and size, and clears the beat counter.
  - It then goes to DELAY with cnt=LATENCY, or directly to BURST if LATENCY=0.
- **DELAY:**
  - arready=0 and rvalid=0.
  - cnt decrements each cycle. When cnt reaches 0 the block loads the first beat and enters BURST.
- **BURST:**
  - rvalid=1. rdata, rresp, rlast and rid are registered and held stable while rvalid&~rready.
  - On rvalid&rready:
    - if beat==len, the block goes to IDLE;
    - otherwise beat increments and the next beat is loaded.
- **Address advance** (byte address, 32-bit arithmetic, wrap mod 2^32):
  - FIXED: the address is unchanged.
  - INCR: addr+4.
  - WRAP: the wrap boundary is (len+1)*4. The next address is (addr & ~(bound-1)) | ((addr+4) & (bound-1)).
  - WRAP with len not in {1,3,7,15} is treated as INCR.
- **Reserved arburst=11:** every beat returns SLVERR with rdata=0. The beat count still follows len.
- **Word index:** (addr-BASE_ADDR)>>2. An address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) returns rresp=DECERR and rdata=0 for that beat only. Each beat of a burst is checked independently.
- **arsize≠010:** SLVERR and rdata=0 on every beat. Address low bits [1:0] are ignored.
- **Reset values:** state=IDLE, rvalid=0, rlast=0, rresp=00, rdata=0, rid=0. arready=0 while reset is asserted and 1 in the first cycle after it.
- **Reset mid-burst or mid-delay:** the transaction is abandoned. No further beats are issued for it.

## Timing
- AR handshake in cycle T → the first rvalid is visible in cycle T+LATENCY+1.
- Beats are back-to-back while rready=1: one beat per cycle.
- The last beat is accepted in cycle U → arready=1 in cycle U+1. There is one dead cycle between bursts; AR is never accepted in the same cycle as an R beat.
- The total cycle count for a burst of len+1 beats with rready held high is LATENCY+len+2, counted from the AR handshake to return to IDLE.

## Configuration
- AXI_RD_RAND_DELAY_EN:
  - **When defined:** a 16-bit LFSR (seed 16'hACE1 at reset, polynomial x^16+x^14+x^13+x^11+1) inserts 0–3 bubble cycles, taken from lfsr[1:0], before each beat after the first. During a bubble, rvalid=0. Ordering, data and rlast are unchanged. This mode stresses the initiator's rvalid handling.
  - **When not defined:** there are no bubbles, and the LFSR logic is absent.

## Test plan
- **Single read:** LATENCY=2, mem[0]=32'hDEADBEEF, AR addr 32'h80000000, len=0, INCR, id=5, rready=1 → one beat in cycle T+3 with rdata=DEADBEEF, rresp=00, rlast=1, rid=5; arready=1 in cycle T+4.
- **INCR burst with backpressure:** mem[i]=i, addr 32'h80000010, len=3, rready toggling 1,0,1,0… → rdata 4,5,6,7 in order; each beat is held stable across its stall cycle; rlast only with 7.
- **WRAP burst:** addr 32'h80000018, len=3 → words 6,7,4,5; rlast with 5.
- **Errors:**
  - addr 32'h7FFFFFFC, len=1, INCR → beat0 rresp=11 with rdata=0; beat1 (32'h80000000) rresp=00 with mem[0].
  - arsize=3'b001 → SLVERR on each beat.
- **Reset mid-burst:** assert reset during beat 2 of a len=7 burst → rvalid=0 the next cycle; after reset deasserts, arready=1 and no stale beats appear.
- **Back-to-back ARs with LATENCY=0:** arvalid held high with 2 requests → the second handshake occurs exactly one cycle after the first request's last beat is accepted; the first beat of each request follows its handshake by 1 cycle.

Source files
------------

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder over a word-addressed memory with programmable access latency.
// Define AXI_RD_RAND_DELAY_EN to insert LFSR-driven bubble cycles between beats of a burst.
module axi_rd_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ID_W        = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            arvalid,
  output logic            arready,
  input  logic [31:0]     araddr,
  input  logic [ID_W-1:0] arid,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  output logic            rvalid,
  input  logic            rready,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic [ID_W-1:0] rid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN        = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT         = 4'(LATENCY);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  logic [31:0] mem_r [DEPTH_WORDS];

  state_t          state_r, state_s;
  logic            idle_r;
  logic [3:0]      cnt_r, cnt_s;
  logic [7:0]      beat_r, beat_s;
  logic [7:0]      len_r, len_s;
  logic [31:0]     addr_r, addr_s;
  logic [ID_W-1:0] id_r, id_s;
  logic [1:0]      burst_r, burst_s;
  logic [2:0]      size_r, size_s;
  logic            rvalid_r, rvalid_s;
  logic [31:0]     rdata_r, rdata_s;
  logic [1:0]      rresp_r, rresp_s;
  logic            rlast_r, rlast_s;
  logic [ID_W-1:0] rid_r, rid_s;

  logic            ar_hs_s;
  logic            load_s;
  logic [31:0]     src_addr_s;
  logic [2:0]      src_size_s;
  logic [1:0]      src_burst_s;
  logic [7:0]      src_beat_s;
  logic [7:0]      src_len_s;
  logic [ID_W-1:0] src_id_s;
  logic [31:0]     off_s;
  logic            in_range_s;
  logic [1:0]      beat_resp_s;
  logic [31:0]     beat_data_s;

`ifdef AXI_RD_RAND_DELAY_EN
  logic [15:0]     lfsr_r;
  logic [1:0]      bub_r, bub_s;
  logic            hold_s;
`endif

  // Byte address of the beat following addr; WRAP only wraps for legal lengths.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = addr + 32'd4;
    mask = ({24'd0, len} << 2) | 32'd3;
    case (burst)
      2'b00: next_addr = addr;
      2'b10: begin
        if ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)) begin
          next_addr = (addr & ~mask) | (step & mask);
        end else begin
          next_addr = step;
        end
      end
      default: next_addr = step;
    endcase
  endfunction

  // Request-level errors dominate the per-beat address decode.
  function automatic logic [1:0] beat_status(input logic [1:0] burst, input logic [2:0] size,
                                             input logic in_range);
    if ((burst == 2'b11) || (size != 3'b010)) begin
      beat_status = RESP_SLVERR;
    end else if (!in_range) begin
      beat_status = RESP_DECERR;
    end else begin
      beat_status = RESP_OKAY;
    end
  endfunction

  assign arready = idle_r && !reset;
  assign ar_hs_s = arvalid && arready;

  // Source of the beat about to be loaded: AR bus, captured request, or advanced address.
  always_comb begin
    src_addr_s  = addr_r;
    src_size_s  = size_r;
    src_burst_s = burst_r;
    src_beat_s  = beat_r;
    src_len_s   = len_r;
    src_id_s    = id_r;
    case (state_r)
      ST_IDLE: begin
        src_addr_s  = araddr;
        src_size_s  = arsize;
        src_burst_s = arburst;
        src_beat_s  = 8'd0;
        src_len_s   = arlen;
        src_id_s    = arid;
      end
      ST_BURST: begin
        src_addr_s = next_addr(addr_r, len_r, burst_r);
        src_beat_s = beat_r + 8'd1;
      end
      default: begin
        src_addr_s = addr_r;
      end
    endcase
  end

  assign off_s       = src_addr_s - BASE_ADDR;
  assign in_range_s  = ({1'b0, off_s} < SPAN);
  assign beat_resp_s = beat_status(src_burst_s, src_size_s, in_range_s);
  assign beat_data_s = (beat_resp_s == RESP_OKAY) ? mem_r[off_s[AW+1:2]] : 32'd0;

  // Next-state and next-output logic for the IDLE/DELAY/BURST sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    beat_s   = beat_r;
    len_s    = len_r;
    addr_s   = addr_r;
    id_s     = id_r;
    burst_s  = burst_r;
    size_s   = size_r;
    rvalid_s = rvalid_r;
    rdata_s  = rdata_r;
    rresp_s  = rresp_r;
    rlast_s  = rlast_r;
    rid_s    = rid_r;
    load_s   = 1'b0;
`ifdef AXI_RD_RAND_DELAY_EN
    bub_s    = bub_r;
    hold_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (ar_hs_s) begin
          addr_s  = araddr;
          id_s    = arid;
          len_s   = arlen;
          burst_s = arburst;
          size_s  = arsize;
          beat_s  = 8'd0;
          if (LAT == 4'd0) begin
            state_s = ST_BURST;
            load_s  = 1'b1;
          end else begin
            state_s = ST_DELAY;
            cnt_s   = LAT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (cnt_r <= 4'd1) begin
          state_s = ST_BURST;
          cnt_s   = 4'd0;
          load_s  = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_BURST: begin
        if (rvalid_r && rready) begin
          if (beat_r == len_r) begin
            state_s  = ST_IDLE;
            rvalid_s = 1'b0;
            rlast_s  = 1'b0;
          end else begin
            beat_s = src_beat_s;
            addr_s = src_addr_s;
            load_s = 1'b1;
`ifdef AXI_RD_RAND_DELAY_EN
            bub_s  = lfsr_r[1:0];
            hold_s = (lfsr_r[1:0] != 2'd0);
`endif
          end
        end else begin
`ifdef AXI_RD_RAND_DELAY_EN
          // A bubble is in progress whenever BURST holds rvalid low.
          if (!rvalid_r && (bub_r <= 2'd1)) begin
            rvalid_s = 1'b1;
            bub_s    = 2'd0;
          end else if (!rvalid_r) begin
            bub_s = bub_r - 2'd1;
          end else begin
            bub_s = bub_r;
          end
`else
          state_s = ST_BURST;
`endif
        end
      end
      default: begin
        state_s  = ST_IDLE;
        rvalid_s = 1'b0;
      end
    endcase
    if (load_s) begin
      rvalid_s = 1'b1;
      rdata_s  = beat_data_s;
      rresp_s  = beat_resp_s;
      rlast_s  = (src_beat_s == src_len_s);
      rid_s    = src_id_s;
`ifdef AXI_RD_RAND_DELAY_EN
      if (hold_s) begin
        rvalid_s = 1'b0;
      end else begin
        rvalid_s = 1'b1;
      end
`endif
    end else begin
      rdata_s = rdata_s;
    end
  end

  // Sequencer state, captured request and registered R-channel outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      idle_r   <= 1'b1;
      cnt_r    <= 4'd0;
      beat_r   <= 8'd0;
      len_r    <= 8'd0;
      addr_r   <= 32'd0;
      id_r     <= {ID_W{1'b0}};
      burst_r  <= 2'd0;
      size_r   <= 3'd0;
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
      rresp_r  <= 2'd0;
      rlast_r  <= 1'b0;
      rid_r    <= {ID_W{1'b0}};
    end else begin
      state_r  <= state_s;
      idle_r   <= (state_s == ST_IDLE);
      cnt_r    <= cnt_s;
      beat_r   <= beat_s;
      len_r    <= len_s;
      addr_r   <= addr_s;
      id_r     <= id_s;
      burst_r  <= burst_s;
      size_r   <= size_s;
      rvalid_r <= rvalid_s;
      rdata_r  <= rdata_s;
      rresp_r  <= rresp_s;
      rlast_r  <= rlast_s;
      rid_r    <= rid_s;
    end
  end

`ifdef AXI_RD_RAND_DELAY_EN
  // Free-running x^16+x^14+x^13+x^11+1 LFSR and bubble countdown.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
      bub_r  <= 2'd0;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      bub_r  <= bub_s;
    end
  end
`endif

  assign rvalid = rvalid_r;
  assign rdata  = rdata_r;
  assign rresp  = rresp_r;
  assign rlast  = rlast_r;
  assign rid    = rid_r;

endmodule
